// File: rtl/status_link_pkg.sv
// Shared definitions for the serial status link: frame layout, line levels,
// transmitter state encoding and the parity rule. The receiver imports it too.
package status_link_pkg;

  localparam int unsigned STATUS_W   = 9;
  localparam int unsigned HI_W       = 6;
  localparam int unsigned LO_W       = 3;
  localparam int unsigned FRAME_BITS = 12;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Parity bit for a status word; odd parity makes the total count of ones odd.
  function automatic logic parity_bit(input logic [STATUS_W-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/status_bit_timer.sv
// Bit-period timer: counts sysclk cycles within one serial bit and flags the
// last cycle (bit_end) and the second-to-last cycle (pre_end) of each period.
module status_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic pre_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  // Only meaningful when a bit spans at least two cycles.
  localparam logic [CntW-1:0] PreCnt = (CLKS_PER_BIT > 1) ? CntW'(CLKS_PER_BIT - 2) : '0;
  localparam logic HasPre = (CLKS_PER_BIT > 1);

  logic [CntW-1:0] cnt_q;

  // Cycle counter: cleared on a new word, wraps at the bit boundary, parked at 0 when idle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == LastCnt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Boundary flags decoded from the current count.
  always_comb begin
    bit_end = enable && (cnt_q == LastCnt);
    pre_end = enable && HasPre && (cnt_q == PreCnt);
  end

endmodule

// File: rtl/status_word_tx.sv
// Bit-serial transmitter for the 9-bit status word {hi, lo}: start bit, data
// LSB first, parity, stop. One word per valid/ready handshake, frames may be
// sent back to back with no idle gap.
module status_word_tx
  import status_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b1
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic [HI_W-1:0] st_hi,
  input  logic [LO_W-1:0] st_lo,
  input  logic            st_valid,
  output logic            st_ready,
  output logic            oval,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [3:0] LastIdx = 4'(STATUS_W - 1);
  localparam logic       OneClk  = (CLKS_PER_BIT == 1);

  tx_state_e           state_q;
  logic [STATUS_W-1:0] shreg_q;
  logic [3:0]          idx_q;
  logic                par_q;
  logic                oval_q;
  logic                frame_done_q;

  logic bit_end;
  logic pre_end;
  logic accept;

  status_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (accept),
    .enable (busy),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  // Handshake: ready when idle or in the final cycle of the stop bit.
  always_comb begin
    busy     = (state_q != StIdle);
    st_ready = (state_q == StIdle) || ((state_q == StStop) && bit_end);
    accept   = st_valid && st_ready;
  end

  // Frame FSM with shift register, captured parity and registered line/done outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      idx_q        <= '0;
      par_q        <= 1'b0;
      oval_q       <= LINE_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      // Raised one cycle early so the registered pulse lands on the last stop cycle.
      frame_done_q <= ((state_q == StStop) && pre_end) ||
                      (OneClk && (state_q == StParity) && bit_end);
      if (accept) begin
        shreg_q <= {st_hi, st_lo};
        par_q   <= parity_bit({st_hi, st_lo}, PARITY_ODD);
        idx_q   <= '0;
        state_q <= StStart;
        oval_q  <= START_LVL;
      end else begin
        case (state_q)
          StIdle: begin
            oval_q <= LINE_IDLE;
          end
          StStart: begin
            if (bit_end) begin
              state_q <= StData;
              oval_q  <= shreg_q[0];
            end
          end
          StData: begin
            if (bit_end) begin
              shreg_q <= shreg_q >> 1;
              if (idx_q == LastIdx) begin
                idx_q   <= '0;
                state_q <= StParity;
                oval_q  <= par_q;
              end else begin
                idx_q  <= idx_q + 4'd1;
                oval_q <= shreg_q[1];
              end
            end
          end
          StParity: begin
            if (bit_end) begin
              state_q <= StStop;
              oval_q  <= LINE_IDLE;
            end
          end
          StStop: begin
            if (bit_end) begin
              state_q <= StIdle;
              oval_q  <= LINE_IDLE;
            end
          end
          default: begin
            state_q <= StIdle;
            oval_q  <= LINE_IDLE;
          end
        endcase
      end
    end
  end

  assign oval       = oval_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_status_word_tx.sv
// Bench for status_word_tx: three instances (4 clk/bit odd, 4 clk/bit even,
// 1 clk/bit odd) checked against a frame-level reference model.
module tb_status_word_tx;

  localparam int CPB [3] = '{4, 4, 1};
  localparam bit ODD [3] = '{1'b1, 1'b0, 1'b1};

  logic       sysclk = 1'b0;
  logic       reset;
  logic [5:0] hi    [3];
  logic [2:0] lo    [3];
  logic       valid [3];
  logic       ready [3];
  logic       oval_w[3];
  logic       busy_w[3];
  logic       fd_w  [3];

  int tests_run    = 0;
  int tests_failed = 0;

  // Capture results
  logic [127:0] obs;
  logic [127:0] busy_v;
  int           fd_first;
  int           fd_cnt;
  int           rdy_cnt1;
  int           rdy_cnt2;
  logic         timed_out;

  always #5 sysclk = ~sysclk;

  status_word_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_odd4 (
    .sysclk(sysclk), .reset(reset), .st_hi(hi[0]), .st_lo(lo[0]), .st_valid(valid[0]),
    .st_ready(ready[0]), .oval(oval_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  status_word_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_even4 (
    .sysclk(sysclk), .reset(reset), .st_hi(hi[1]), .st_lo(lo[1]), .st_valid(valid[1]),
    .st_ready(ready[1]), .oval(oval_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  status_word_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) u_odd1 (
    .sysclk(sysclk), .reset(reset), .st_hi(hi[2]), .st_lo(lo[2]), .st_valid(valid[2]),
    .st_ready(ready[2]), .oval(oval_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  // Reference parity: odd parity makes the ones count of data+parity odd.
  function automatic logic ref_par(input logic [8:0] w, input bit odd);
    int ones = $countones(w);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Expected line level for cycles 1..ncyc after the first accept (bit c-1 = cycle c).
  function automatic logic [127:0] exp_line(input logic [8:0] w1, input logic [8:0] w2,
                                            input int nframes, input int c, input bit odd,
                                            input int ncyc);
    logic [127:0] r = '0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      int frame  = (cyc - 1) / (12 * c);
      int bitpos = ((cyc - 1) % (12 * c)) / c;
      logic [8:0] w = (frame == 0) ? w1 : w2;
      if (frame >= nframes)  r[cyc-1] = 1'b1;
      else if (bitpos == 0)  r[cyc-1] = 1'b0;
      else if (bitpos <= 9)  r[cyc-1] = w[bitpos-1];
      else if (bitpos == 10) r[cyc-1] = ref_par(w, odd);
      else                   r[cyc-1] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [127:0] ones_mask(input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Offer w_first, switch inputs to w_after right after the accept, record ncyc cycles.
  task automatic run_capture(input int k, input int ncyc, input logic [8:0] w_first,
                             input logic [8:0] w_after, input int drop_at);
    int n = 0;
    obs = '0; busy_v = '0; fd_first = 0; fd_cnt = 0; rdy_cnt1 = 0; rdy_cnt2 = 0;
    timed_out = 1'b0;
    @(negedge sysclk);
    hi[k] = w_first[8:3]; lo[k] = w_first[2:0]; valid[k] = 1'b1;
    while (!ready[k] && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    if (!ready[k]) timed_out = 1'b1;
    @(posedge sysclk);
    #1;
    hi[k] = w_after[8:3]; lo[k] = w_after[2:0];
    if (drop_at == 0) valid[k] = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge sysclk);
      obs[c-1]    = oval_w[k];
      busy_v[c-1] = busy_w[k];
      if (fd_w[k]) begin
        fd_cnt++;
        if (fd_first == 0) fd_first = c;
      end
      if (ready[k]) begin
        if (c <= 12 * CPB[k]) rdy_cnt1++;
        else rdy_cnt2++;
      end
      if (c == drop_at) valid[k] = 1'b0;
    end
    valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({oval_w[k], ready[k], busy_w[k], fd_w[k]} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got {oval,ready,busy,done}=%b want 1100", k,
                 {oval_w[k], ready[k], busy_w[k], fd_w[k]});
      end
    end
  endtask

  // Check line shape, done pulse and timeout for one single-frame capture.
  task automatic check_frame(input string name, input int k, input logic [8:0] w, input int ncyc);
    logic [127:0] e = exp_line(w, w, 1, CPB[k], ODD[k], ncyc);
    tests_run++;
    if (timed_out !== 1'b0 || obs !== e) begin
      tests_failed++;
      $display("FAIL %s line: got %h want %h (timeout=%b)", name, obs, e, timed_out);
    end
    tests_run++;
    if (fd_first != 12 * CPB[k] || fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s done: got first=%0d count=%0d want first=%0d count=1", name, fd_first,
               fd_cnt, 12 * CPB[k]);
    end
  endtask

  task automatic test_single_odd();
    run_capture(0, 52, 9'h155, 9'h155, 0);
    check_frame("single_odd", 0, 9'h155, 52);
    tests_run++;
    if (obs[40] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_odd parity: got %b want 0", obs[40]);
    end
  endtask

  task automatic test_even_parity();
    run_capture(1, 52, 9'h155, 9'h155, 0);
    check_frame("even_155", 1, 9'h155, 52);
    tests_run++;
    if (obs[40] !== 1'b1) begin
      tests_failed++;
      $display("FAIL even_155 parity: got %b want 1", obs[40]);
    end
    run_capture(1, 52, 9'h000, 9'h000, 0);
    check_frame("even_000", 1, 9'h000, 52);
    tests_run++;
    if (obs[40] !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_000 parity: got %b want 0", obs[40]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        logic [8:0] w = 9'($urandom);
        run_capture(k, 13 * CPB[k], w, w, 0);
        check_frame($sformatf("random[%0d] w=%h", k, w), k, w, 13 * CPB[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e = exp_line(9'h1FF, 9'h000, 2, 4, 1'b1, 96);
    run_capture(0, 96, 9'h1FF, 9'h000, 49);
    tests_run++;
    if (timed_out !== 1'b0 || obs !== e) begin
      tests_failed++;
      $display("FAIL b2b line: got %h want %h", obs, e);
    end
    tests_run++;
    if (busy_v !== ones_mask(96)) begin
      tests_failed++;
      $display("FAIL b2b busy: got %h want %h", busy_v, ones_mask(96));
    end
    tests_run++;
    if (rdy_cnt1 != 1 || rdy_cnt2 != 1 || fd_cnt != 2 || fd_first != 48) begin
      tests_failed++;
      $display("FAIL b2b ready/done: got rdy=%0d/%0d done=%0d first=%0d want 1/1 2 48",
               rdy_cnt1, rdy_cnt2, fd_cnt, fd_first);
    end
    @(negedge sysclk);
    tests_run++;
    if ({oval_w[0], ready[0], busy_w[0]} !== 3'b110) begin
      tests_failed++;
      $display("FAIL b2b idle: got {oval,ready,busy}=%b want 110",
               {oval_w[0], ready[0], busy_w[0]});
    end
  endtask

  task automatic test_ignore_busy();
    logic [8:0] w  = 9'($urandom);
    logic [8:0] w2 = ~w;
    run_capture(0, 56, w, w2, 47);
    check_frame("ignore_busy", 0, w, 56);
    tests_run++;
    if (busy_v !== ones_mask(48)) begin
      tests_failed++;
      $display("FAIL ignore_busy busy: got %h want %h", busy_v, ones_mask(48));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w = 9'($urandom);
    run_capture(0, 22, 9'h1EF, 9'h1EF, 0);
    tests_run++;
    if (obs[21] !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset pre: got oval=%b want 0", obs[21]);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({oval_w[0], ready[0], busy_w[0]} !== 3'b110) begin
      tests_failed++;
      $display("FAIL midreset async: got {oval,ready,busy}=%b want 110",
               {oval_w[0], ready[0], busy_w[0]});
    end
    @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    run_capture(0, 52, w, w, 0);
    check_frame("after_reset", 0, w, 52);
  endtask

  task automatic test_one_clk();
    run_capture(2, 14, 9'h0AA, 9'h0AA, 0);
    check_frame("cpb1_0aa", 2, 9'h0AA, 14);
    tests_run++;
    if (obs[10] !== ref_par(9'h0AA, 1'b1) || busy_v !== ones_mask(12)) begin
      tests_failed++;
      $display("FAIL cpb1 parity/busy: got par=%b busy=%h want par=%b busy=%h", obs[10],
               busy_v, ref_par(9'h0AA, 1'b1), ones_mask(12));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hi[k] = '0; lo[k] = '0; valid[k] = 1'b0;
    end
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    test_reset();
    test_single_odd();
    test_even_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_one_clk();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
